note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Initiator side of the duration_counter load/done interface.
- Walks a song table in synchronous-read memory, one word per note.
- For each note, presents pitch and gate to the voice, then issues a one-cycle load with the note duration to duration_counter.
- Waits for that counter's done pulse, then advances. Supports stop, end-of-song and optional looping.

Parameters:
- ADDR_WIDTH, 8, song table address width; the table holds 2^ADDR_WIDTH words.
- PITCH_WIDTH, 6, width of the pitch field and of o_pitch.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; one clock; asynchronous, active-low.
- i_start  in  1  one-cycle pulse; starts playback at address 0. Honoured only in IDLE.
- i_stop  in  1  one-cycle pulse; aborts playback.
- i_loop  in  1  level; sampled when an end marker is decoded.
- o_rd_en  out  1  memory read strobe.
- o_addr  out  ADDR_WIDTH  memory address (registered).
- i_data  in  PITCH_WIDTH+7  memory word, valid the cycle after o_rd_en.
- o_load  out  1  one-cycle load pulse to duration_counter.
- o_duration  out  5  duration sent with o_load.
- i_done  in  1  done pulse from duration_counter.
- o_pitch  out  PITCH_WIDTH  current pitch (registered).
- o_gate  out  1  voice on (registered).
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:

Word format (LSB first):
- [4:0] duration
- [4+PITCH_WIDTH:5] pitch
- [5+PITCH_WIDTH] rest: gate low for this note, duration still counted
- [6+PITCH_WIDTH] end marker: other fields ignored

Reset (async, i_rst_n=0):
- state=IDLE, o_addr=0, o_pitch=0, o_gate=0, played flag=0.
- All outputs low.

States: IDLE, FETCH, DECODE, PLAY. Any unused encoding goes to IDLE.
- IDLE: on i_start, go to FETCH with o_addr=0 and played=0.
- FETCH: o_rd_en=1 for exactly one cycle, then go to DECODE.
- DECODE (i_data valid):
  - If end marker, i_loop=1 and played=1: o_addr<=0, played<=0, go to FETCH.
  - If end marker otherwise: o_gate<=0, go to IDLE. This covers an empty loop, so it cannot spin forever.
  - Else (note or rest):
    - o_load=1 combinationally this cycle; o_duration=i_data[4:0].
    - o_pitch<=pitch field, o_gate<=~rest, played<=1.
    - Go to PLAY.
- PLAY: wait for i_done. On i_done: o_addr<=o_addr+1, go to FETCH. o_gate holds its value.

Timing:
- i_start to first o_load: 2 cycles (IDLE→FETCH→DECODE).
- i_done to next o_load: 2 cycles.
- o_gate/o_pitch update on the clock edge that ends DECODE.
- The gap between notes is 2 cycles with the previous pitch/gate held. This avoids clicks.

Boundary conditions:
- Address wrap: o_addr at 2^ADDR_WIDTH-1 increments to 0. No end marker is implied.
- i_stop, synchronous, any non-IDLE state: next state IDLE, o_gate<=0, o_load suppressed that cycle. o_pitch keeps its value.
- i_stop and i_start in the same cycle: stop wins.
- i_start while busy: ignored.
- i_done outside PLAY: ignored.
- i_done in the same cycle as i_stop: stop wins, no advance.
- Duration 0 is legal and is passed through unchanged. The counter produces done on its first enable.
- o_load is never asserted in two consecutive cycles.
- Reset mid-note: immediate return to IDLE, o_gate=0.

Test Plan:
- Reset and start: release reset, table {pitch 10 dur 3; end}, i_loop=0, pulse i_start.
  - o_rd_en at cycle 1.
  - o_load with o_duration=3 at cycle 2.
  - o_pitch=10, o_gate=1 from cycle 3.
  - Drive i_done: next FETCH at addr 1, then IDLE with o_gate=0, o_busy=0.
- Rest note: word with rest=1, dur 5 -> o_load with o_duration=5, o_gate=0, o_pitch updated.
- Loop: table {A; B; end}, i_loop=1, i_done 4 cycles after each load -> address sequence 0,1,2,0,1,… and loads A,B,A,B.
- Empty loop: table {end} at addr 0, i_loop=1 -> returns to IDLE after one DECODE with no o_load.
- Stop races:
  - i_stop with i_done in the same PLAY cycle -> IDLE, o_addr unchanged, no further o_rd_en.
  - i_stop together with i_start in IDLE -> stays IDLE.
- Wrap and async reset:
  - ADDR_WIDTH=2 with no end marker -> o_addr 3→0.
  - Assert i_rst_n low mid-PLAY between clock edges -> o_gate and o_busy drop immediately.

Source files
------------

// File: rtl/note_sequencer.sv
// Song-table walker: fetches one word per note, drives the voice,
// loads duration_counter and advances on its done pulse.
module note_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PITCH_WIDTH = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_loop,
  output logic                   o_rd_en,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  input  logic [PITCH_WIDTH+6:0] i_data,
  output logic                   o_load,
  output logic [4:0]             o_duration,
  input  logic                   i_done,
  output logic [PITCH_WIDTH-1:0] o_pitch,
  output logic                   o_gate,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    PLAY
  } state_t;

  state_t state;
  state_t state_nx;
  logic   played;

  logic [4:0]             w_dur;
  logic [PITCH_WIDTH-1:0] w_pitch;
  logic                   w_rest;
  logic                   w_end;

  assign w_dur   = i_data[4:0];
  assign w_pitch = i_data[4+PITCH_WIDTH:5];
  assign w_rest  = i_data[5+PITCH_WIDTH];
  assign w_end   = i_data[6+PITCH_WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_start) state_nx = FETCH;
      end
      FETCH: begin
        state_nx = DECODE;
      end
      DECODE: begin
        if (w_end) begin
          // played guards against spinning on a table that starts with end
          state_nx = (i_loop && played) ? FETCH : IDLE;
        end else begin
          state_nx = PLAY;
        end
      end
      PLAY: begin
        if (i_done) state_nx = FETCH;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (i_stop) state_nx = IDLE;
  end

  always_comb begin
    o_rd_en    = (state == FETCH);
    o_load     = (state == DECODE) && !w_end && !i_stop;
    o_duration = o_load ? w_dur : 5'd0;
    o_busy     = (state != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_addr  <= '0;
      o_pitch <= '0;
      o_gate  <= 1'b0;
      played  <= 1'b0;
    end else if (i_stop) begin
      if (state != IDLE) o_gate <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            o_addr <= '0;
            played <= 1'b0;
          end
        end
        DECODE: begin
          if (w_end) begin
            if (i_loop && played) begin
              o_addr <= '0;
              played <= 1'b0;
            end else begin
              o_gate <= 1'b0;
            end
          end else begin
            o_pitch <= w_pitch;
            o_gate  <= ~w_rest;
            played  <= 1'b1;
          end
        end
        PLAY: begin
          if (i_done) o_addr <= o_addr + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: scoreboard of expected loads plus
// directed checks of addressing, gate, stop races and reset.
module tb_note_sequencer;

  localparam int AW = 2;
  localparam int PW = 6;
  localparam logic [12:0] ENDW = 13'h1000;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic          i_stop;
  logic          i_loop;
  logic          o_rd_en;
  logic [AW-1:0] o_addr;
  logic [12:0]   i_data;
  logic          o_load;
  logic [4:0]    o_duration;
  logic          i_done;
  logic [PW-1:0] o_pitch;
  logic          o_gate;
  logic          o_busy;

  logic [12:0] mem [4];
  logic [6:0]  sb [$];
  logic        prev_load = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_addr [5] = '{0, 1, 2, 0, 1};

  note_sequencer #(
    .ADDR_WIDTH (AW),
    .PITCH_WIDTH(PW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_loop    (i_loop),
    .o_rd_en   (o_rd_en),
    .o_addr    (o_addr),
    .i_data    (i_data),
    .o_load    (o_load),
    .o_duration(o_duration),
    .i_done    (i_done),
    .o_pitch   (o_pitch),
    .o_gate    (o_gate),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_rd_en) i_data <= mem[o_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_load) begin
      check("load_b2b", 32'(prev_load), 0);
      check("sb_avail", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) check("sb_load", {o_addr, o_duration}, sb.pop_front());
    end
    prev_load = o_load;
  end

  function automatic logic [12:0] nw(int p, int d, bit r);
    return {1'b0, r, 6'(p), 5'(d)};
  endfunction

  function automatic logic [6:0] ld(int a, int d);
    return {2'(a), 5'(d)};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_loop  = 1'b0;
    i_done  = 1'b0;
    i_data  = '0;
    for (int i = 0; i < 4; i++) mem[i] = ENDW;
    step();
    step();
    check("rst_busy", o_busy, 0);
    check("rst_gate", o_gate, 0);
    check("rst_addr", o_addr, 0);
    check("rst_pitch", o_pitch, 0);
    check("rst_rd", o_rd_en, 0);
    check("rst_load", o_load, 0);
    i_rst_n = 1'b1;
    step();

    // single note then end
    mem[0] = nw(10, 3, 0);
    mem[1] = ENDW;
    sb.push_back(ld(0, 3));
    pulse_start();
    check("t1_rd", o_rd_en, 1);
    check("t1_busy", o_busy, 1);
    step();
    check("t1_load", o_load, 1);
    step();
    check("t1_pitch", o_pitch, 10);
    check("t1_gate", o_gate, 1);
    check("t1_noload", o_load, 0);
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    check("t1_addr", o_addr, 1);
    check("t1_rd2", o_rd_en, 1);
    step();
    check("t1_endload", o_load, 0);
    step();
    check("t1_idle", o_busy, 0);
    check("t1_gateoff", o_gate, 0);

    // rest note
    mem[0] = nw(7, 5, 1);
    sb.push_back(ld(0, 5));
    pulse_start();
    step();
    check("rest_dur", o_duration, 5);
    step();
    check("rest_pitch", o_pitch, 7);
    check("rest_gate", o_gate, 0);
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    step();
    step();
    check("rest_idle", o_busy, 0);

    // looping A,B,end with a stop racing done
    mem[0] = nw(20, 2, 0);
    mem[1] = nw(30, 4, 0);
    mem[2] = ENDW;
    i_loop = 1'b1;
    sb.push_back(ld(0, 2));
    sb.push_back(ld(1, 4));
    sb.push_back(ld(0, 2));
    sb.push_back(ld(1, 4));
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      check("loop_addr", o_addr, exp_addr[k]);
      check("loop_rd", o_rd_en, 1);
      step();
      if (exp_addr[k] == 2) begin
        check("loop_endload", o_load, 0);
        step();
        continue;
      end
      step();
      step();
      step();
      if (k == 4) break;
      i_done = 1'b1;
      step();
      i_done = 1'b0;
    end
    i_stop = 1'b1;
    i_done = 1'b1;
    step();
    i_stop = 1'b0;
    i_done = 1'b0;
    check("stop_busy", o_busy, 0);
    check("stop_addr", o_addr, 1);
    check("stop_gate", o_gate, 0);
    check("stop_pitch", o_pitch, 30);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stop_nord", o_rd_en, 0);
    end

    // empty loop
    mem[0] = ENDW;
    pulse_start();
    step();
    check("empty_load", o_load, 0);
    step();
    check("empty_idle", o_busy, 0);

    // stop beats start
    i_start = 1'b1;
    i_stop  = 1'b1;
    step();
    i_start = 1'b0;
    i_stop  = 1'b0;
    check("ss_idle", o_busy, 0);
    i_loop = 1'b0;

    // address wrap, duration 0, async reset mid-note
    for (int k = 0; k < 4; k++) mem[k] = nw(k + 1, k, 0);
    for (int k = 0; k < 5; k++) sb.push_back(ld(k % 4, k % 4));
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      check("wrap_addr", o_addr, k % 4);
      step();
      step();
      check("wrap_pitch", o_pitch, (k % 4) + 1);
      if (k == 4) break;
      i_done = 1'b1;
      step();
      i_done = 1'b0;
    end
    check("arst_pre_gate", o_gate, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_gate", o_gate, 0);
    check("arst_busy", o_busy, 0);
    step();
    i_rst_n = 1'b1;
    step();
    check("arst_idle", o_busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
